xfer2ringbuf_gen: RTL and testbench

Parametrised successor of the 16-channel sample-transfer block in the DAQ path. On each RDY, moves NSAMP samples from each enabled per-channel FIFO into the ring buffer, one channel after another. It drives one-hot FIFO read enables, a muxed write word and a write strobe. The transfer FSM is internal. New relative to the fixed 16x12 design:
- runtime channel masking
- configurable FIFO read latency
- fixed-length underflow padding
- per-word channel tag and BUSY status

---
 rtl/xfer2ringbuf_pkg.sv | 19 +
 rtl/xfer2ringbuf_gen_chan_sel.sv | 25 ++
 rtl/xfer2ringbuf_gen.sv | 203 ++++++++++++++++++++
 tb/tb_xfer2ringbuf_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/xfer2ringbuf_pkg.sv
// Shared types and helpers for the xfer2ringbuf_gen sample-transfer block.
package xfer2ringbuf_pkg;

    localparam int unsigned MaxChanW = 5;

    typedef enum logic [2:0] {IDLE, SCAN, READ, DRAIN, DONE} xstate_t;

    function automatic int unsigned CHAN_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One read slot travelling down the FIFO-latency pipeline.
    typedef struct packed {
        logic                valid;
        logic                pad;
        logic [MaxChanW-1:0] chan;
    } slot_t;

endpackage

// File: rtl/xfer2ringbuf_gen_chan_sel.sv
// Lowest-set-bit priority encoder over the channel mask, with a found flag.
module xfer_chan_sel
    import xfer2ringbuf_pkg::*;
#(
    parameter int unsigned NCHAN = 16
) (
    input  logic [NCHAN-1:0]          req_i,
    output logic [CHAN_W(NCHAN)-1:0]  idx_o,
    output logic                      found_o
);

    localparam int unsigned CW = CHAN_W(NCHAN);

    always_comb begin
        idx_o = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = CW'(i);
            end
        end
    end

    assign found_o = |req_i;

endmodule

// File: rtl/xfer2ringbuf_gen.sv
// Moves NSAMP samples per enabled channel FIFO into the ring buffer on each RDY.
// Build option: XF2RB_UFLOW_CNT_EN enables the saturating underflow counter.
module xfer2ringbuf_gen
    import xfer2ringbuf_pkg::*;
#(
    parameter int unsigned          NCHAN    = 16,
    parameter int unsigned          SAMPLE_W = 12,
    parameter int unsigned          NSAMP    = 8,
    parameter int unsigned          RD_LAT   = 1,
    parameter logic [SAMPLE_W-1:0]  PAD_VAL  = {SAMPLE_W{1'b1}}
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        JTAG_MODE,
    input  logic                        J_RD_FIFO,
    input  logic [NCHAN-1:0]            CHAN_MASK,
    input  logic                        RDY,
    input  logic [NCHAN-1:0]            F_MT,
    input  logic [NCHAN*SAMPLE_W-1:0]   DIN,
    output logic [NCHAN-1:0]            RD_ENA,
    output logic                        L1A_RD_EN,
    output logic                        WREN,
    output logic [SAMPLE_W-1:0]         DMUX,
    output logic [CHAN_W(NCHAN)-1:0]    WR_CHAN,
    output logic                        PAD,
    output logic                        BUSY,
    output logic [15:0]                 UFLOW_CNT
);

    localparam int unsigned CW        = CHAN_W(NCHAN);
    localparam logic [7:0]  LAST_SAMP = 8'(NSAMP - 1);
    localparam logic [1:0]  DRAIN_END = 2'(RD_LAT);

    xstate_t           state_q, state_d;
    logic [NCHAN-1:0]  mask_q, mask_d;
    logic [CW-1:0]     chan_q, chan_d;
    logic [7:0]        scnt_q, scnt_d;
    logic [1:0]        dcnt_q, dcnt_d;
    logic [NCHAN-1:0]  rd_ena_q, rd_ena_d;
    logic [NCHAN-1:0]  mask_clr, sel_req;
    logic [CW-1:0]     sel_idx;
    logic              sel_found;
    logic              re;

    slot_t             slot_in, slot_out;
    slot_t             pipe_q [RD_LAT];

    logic                wren_q, pad_q;
    logic [SAMPLE_W-1:0] dmux_q;
    logic [CW-1:0]       wr_chan_q;

    assign mask_clr = mask_q & ~(NCHAN'(1) << chan_q);
    // SCAN looks at the whole mask; READ looks ahead past the channel now finishing.
    assign sel_req  = (state_q == SCAN) ? mask_q : mask_clr;

    xfer_chan_sel #(
        .NCHAN (NCHAN)
    ) u_chan_sel (
        .req_i   (sel_req),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        chan_d   = chan_q;
        scnt_d   = scnt_q;
        dcnt_d   = dcnt_q;
        rd_ena_d = '0;
        re       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (JTAG_MODE) begin
                    rd_ena_d = {NCHAN{J_RD_FIFO}};
                end else if (RDY) begin
                    mask_d  = CHAN_MASK;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (sel_found) begin
                    chan_d  = sel_idx;
                    scnt_d  = '0;
                    state_d = READ;
                end else begin
                    dcnt_d  = '0;
                    state_d = DRAIN;
                end
            end
            READ: begin
                re = ~F_MT[chan_q];
                if (re) begin
                    rd_ena_d = NCHAN'(1) << chan_q;
                end
                scnt_d = scnt_q + 8'd1;
                if (scnt_q == LAST_SAMP) begin
                    mask_d = mask_clr;
                    if (sel_found) begin
                        chan_d = sel_idx;
                        scnt_d = '0;
                    end else begin
                        dcnt_d  = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (dcnt_q == DRAIN_END) begin
                    state_d = DONE;
                end else begin
                    dcnt_d = dcnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            chan_q   <= '0;
            scnt_q   <= '0;
            dcnt_q   <= '0;
            rd_ena_q <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            chan_q   <= chan_d;
            scnt_q   <= scnt_d;
            dcnt_q   <= dcnt_d;
            rd_ena_q <= rd_ena_d;
        end
    end

    always_comb begin
        slot_in       = '0;
        slot_in.valid = (state_q == READ);
        slot_in.pad   = (state_q == READ) && F_MT[chan_q];
        slot_in.chan  = (state_q == READ) ? MaxChanW'(chan_q) : '0;
    end

    assign slot_out = pipe_q[RD_LAT-1];

    // Output register is the final stage, giving RD_LAT+1 cycles from READ to WREN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            wren_q    <= 1'b0;
            pad_q     <= 1'b0;
            dmux_q    <= '0;
            wr_chan_q <= '0;
        end else begin
            pipe_q[0] <= slot_in;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            wren_q    <= slot_out.valid;
            pad_q     <= slot_out.valid && slot_out.pad;
            wr_chan_q <= slot_out.valid ? slot_out.chan[CW-1:0] : '0;
            if (!slot_out.valid) begin
                dmux_q <= '0;
            end else if (slot_out.pad) begin
                dmux_q <= PAD_VAL;
            end else begin
                dmux_q <= DIN[int'(slot_out.chan) * SAMPLE_W +: SAMPLE_W];
            end
        end
    end

`ifdef XF2RB_UFLOW_CNT_EN
    logic [15:0] uflow_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            uflow_q <= '0;
        end else if (slot_out.valid && slot_out.pad && (uflow_q != 16'hFFFF)) begin
            uflow_q <= uflow_q + 16'd1;
        end
    end

    assign UFLOW_CNT = uflow_q;
`else
    assign UFLOW_CNT = '0;
`endif

    assign RD_ENA    = rd_ena_q;
    assign L1A_RD_EN = (state_q == DONE);
    assign WREN      = wren_q;
    assign DMUX      = dmux_q;
    assign WR_CHAN   = wr_chan_q;
    assign PAD       = pad_q;
    assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_xfer2ringbuf_gen.sv
// Directed bench for xfer2ringbuf_gen: behavioural channel FIFOs plus an expected-word model.
module tb_xfer2ringbuf_gen #(
    parameter int unsigned RD_LAT = 1
);

    localparam int unsigned NCHAN = 16;
    localparam int unsigned SW    = 12;
    localparam int unsigned NSAMP = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned DI = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    logic                  CLK = 1'b0;
    logic                  RST_N, JTAG_MODE, J_RD_FIFO, RDY;
    logic [NCHAN-1:0]      CHAN_MASK, F_MT, RD_ENA;
    logic [NCHAN*SW-1:0]   DIN;
    logic                  L1A_RD_EN, WREN, PAD, BUSY;
    logic [SW-1:0]         DMUX;
    logic [CW-1:0]         WR_CHAN;
    logic [15:0]           UFLOW_CNT;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ptr [NCHAN];
    logic ptr_clr = 1'b0;
    logic [NCHAN*SW-1:0] din_now;
    logic [NCHAN*SW-1:0] din_dly [RD_LAT];

    xfer2ringbuf_gen #(
        .NCHAN    (NCHAN),
        .SAMPLE_W (SW),
        .NSAMP    (NSAMP),
        .RD_LAT   (RD_LAT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .JTAG_MODE (JTAG_MODE),
        .J_RD_FIFO (J_RD_FIFO),
        .CHAN_MASK (CHAN_MASK),
        .RDY       (RDY),
        .F_MT      (F_MT),
        .DIN       (DIN),
        .RD_ENA    (RD_ENA),
        .L1A_RD_EN (L1A_RD_EN),
        .WREN      (WREN),
        .DMUX      (DMUX),
        .WR_CHAN   (WR_CHAN),
        .PAD       (PAD),
        .BUSY      (BUSY),
        .UFLOW_CNT (UFLOW_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Channel FIFOs: head word of channel k is 0x400|k<<4|ptr; output lags by RD_LAT-1 cycles.
    always @(posedge CLK) begin
        for (int k = 0; k < NCHAN; k++) begin
            if (ptr_clr) ptr[k] <= 0;
            else if (RD_ENA[k]) ptr[k] <= ptr[k] + 1;
        end
        din_dly[0] <= din_now;
        for (int i = 1; i < RD_LAT; i++) din_dly[i] <= din_dly[i-1];
    end

    always_comb begin
        din_now = '0;
        for (int k = 0; k < NCHAN; k++) begin
            din_now[k*SW +: SW] = 12'h400 | 12'(k << 4) | 12'(ptr[k] & 15);
        end
    end

    assign DIN = (RD_LAT == 1) ? din_now : din_dly[DI];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_word(input logic pad, input int chan, input logic [SW-1:0] d);
        return (64'(pad) << 32) | (64'(chan) << 16) | 64'(d);
    endfunction

    task automatic run_event(input logic [NCHAN-1:0] m, input bit uf, input bit jt, input bit abort);
        logic [63:0] exp_q[$];
        logic [63:0] got_q[$];
        logic [NCHAN-1:0] rd_seen = '0;
        logic [NCHAN-1:0] exp_seen = '0;
        int rel = 0, t0 = 0, p = 0;
        int rd_first = -1, rd_total = 0, exp_rd = 0, bad_oh = 0;
        int wren_first = 0, wren_last = 0, l1a_cnt = 0, l1a_cyc = 0, busy_seen = 0;

        for (int k = 0; k < NCHAN; k++) begin
            if (m[k]) begin
                p = 0;
                for (int s = 0; s < NSAMP; s++) begin
                    if (uf && k == 3 && s >= 5) begin
                        exp_q.push_back(pack_word(1'b1, k, 12'hFFF));
                    end else begin
                        exp_q.push_back(pack_word(1'b0, k, 12'h400 | 12'(k << 4) | 12'(p)));
                        p++;
                        exp_rd++;
                        exp_seen[k] = 1'b1;
                    end
                end
            end
        end

        ptr_clr = 1'b1;
        @(negedge CLK);
        ptr_clr   = 1'b0;
        CHAN_MASK = m;
        t0        = cyc;
        RDY       = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            RDY = 1'b0;
            rel = cyc - t0;
            if (RD_ENA != '0) begin
                if (rd_first < 0) rd_first = rel;
                if (!$onehot(RD_ENA)) bad_oh++;
                rd_total += $countones(RD_ENA);
                rd_seen |= RD_ENA;
            end
            if (WREN) begin
                if (got_q.size() == 0) wren_first = rel;
                wren_last = rel;
                got_q.push_back(pack_word(PAD, int'(WR_CHAN), DMUX));
            end
            if (L1A_RD_EN) begin
                l1a_cnt++;
                l1a_cyc = rel;
            end
            if (BUSY) busy_seen = 1;
            // Underflow on channel 3 slots 5..7 of a full-mask event (READ cycles 31..33).
            F_MT      = (uf && rel >= 31 && rel <= 33) ? 16'h0008 : 16'h0000;
            JTAG_MODE = jt && rel >= 5 && rel <= 10;
            J_RD_FIFO = jt;
            if (abort && rel == 45) begin
                #2 RST_N = 1'b0;
                #1 check_val("abort_outs", {RD_ENA, L1A_RD_EN, WREN, DMUX, WR_CHAN, PAD, BUSY,
                                            UFLOW_CNT}, 64'd0);
                @(negedge CLK);
                RST_N = 1'b1;
            end
            if (!abort && l1a_cnt > 0 && rel >= l1a_cyc + 3) break;
        end
        JTAG_MODE = 1'b0;
        J_RD_FIFO = 1'b0;

        if (abort) begin
            check_val("abort_no_l1a", 64'(l1a_cnt), 64'd0);
        end else begin
            check_val("l1a_cnt", 64'(l1a_cnt), 64'd1);
            check_val("word_cnt", 64'(got_q.size()), 64'(exp_q.size()));
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                check_val($sformatf("word%0d", i), got_q[i], exp_q[i]);
            end
            if (exp_q.size() > 0) begin
                check_val("first_rdena", 64'(rd_first), 64'd3);
                check_val("wren_lag", 64'(wren_first - rd_first), 64'(RD_LAT));
                check_val("contig", 64'(wren_last - wren_first), 64'(exp_q.size() - 1));
                check_val("l1a_after_last", 64'(l1a_cyc), 64'(wren_last + 1));
            end else begin
                check_val("l1a_cyc_empty", 64'(l1a_cyc), 64'(3 + RD_LAT));
            end
            check_val("rd_total", 64'(rd_total), 64'(exp_rd));
            check_val("rd_seen", 64'(rd_seen), 64'(exp_seen));
            check_val("rd_onehot", 64'(bad_oh), 64'd0);
            check_val("busy_seen", 64'(busy_seen), 64'd1);
            check_val("busy_idle", 64'(BUSY), 64'd0);
            if (uf) begin
`ifdef XF2RB_UFLOW_CNT_EN
                check_val("uflow_cnt", 64'(UFLOW_CNT), 64'd3);
`else
                check_val("uflow_cnt", 64'(UFLOW_CNT), 64'd0);
`endif
            end
        end
    endtask

    initial begin
        RST_N     = 1'b0;
        JTAG_MODE = 1'b0;
        J_RD_FIFO = 1'b0;
        RDY       = 1'b0;
        CHAN_MASK = '0;
        F_MT      = '0;
        #12;
        check_val("reset_outs", {RD_ENA, L1A_RD_EN, WREN, DMUX, WR_CHAN, PAD, BUSY, UFLOW_CNT},
                  64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        run_event(16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_event(16'h0101, 1'b0, 1'b1, 1'b0);
        run_event(16'h0000, 1'b0, 1'b0, 1'b0);

        // JTAG override in IDLE: RD_ENA follows J_RD_FIFO, RDY ignored.
        @(negedge CLK);
        JTAG_MODE = 1'b1;
        J_RD_FIFO = 1'b1;
        RDY       = 1'b1;
        @(negedge CLK);
        check_val("jtag_rdena_hi", 64'(RD_ENA), 64'hFFFF);
        check_val("jtag_busy", 64'({BUSY, WREN, L1A_RD_EN}), 64'd0);
        J_RD_FIFO = 1'b0;
        @(negedge CLK);
        check_val("jtag_rdena_lo", 64'(RD_ENA), 64'd0);
        JTAG_MODE = 1'b0;
        RDY       = 1'b0;
        @(negedge CLK);
        check_val("jtag_exit_idle", 64'(BUSY), 64'd0);

        run_event(16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_event(16'hFFFF, 1'b0, 1'b0, 1'b1);
        run_event(16'hFFFF, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
